// File: rtl/output_serializer_if.sv
// Stream interface for output_serializer: block input side and beat output side.
interface output_serializer_if #(
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DEPTH   = 2
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               block_done;
  logic [CNT_W-1:0]   fifo_count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid, out_last, block_done, fifo_count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid, out_last, block_done, fifo_count
  );
endinterface

// File: rtl/output_serializer.sv
// Buffers whole cipher blocks in a small FIFO and emits them as OUT_W-bit
// beats over a valid/ready stream, with last-beat marker and done pulse.
module output_serializer #(
  parameter int unsigned BLOCK_W   = 128,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned DEPTH     = 2,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst_,
  output_serializer_if.slave bus
);
  localparam int unsigned BEATS  = BLOCK_W / OUT_W;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0]  FULL      = CNT_W'(DEPTH);
  localparam bit                ONE_BEAT  = (BEATS == 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   count_next;
  logic               in_ready_q;
  logic [BLOCK_W-1:0] shifter;
  logic [BLOCK_W-1:0] shift_next;
  logic [BEAT_W-1:0]  beat;
  logic [BEAT_W-1:0]  beat_next;
  logic               out_valid_q;
  logic               out_last_q;
  logic               block_done_q;
  logic               push;
  logic               pop;
  logic               hs_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode; the next block pops on the final-beat edge so there is no bubble.
  always_comb begin
    push       = bus.in_valid && in_ready_q;
    hs_last    = (state == SHIFT) && bus.out_ready && (beat == LAST_BEAT);
    pop        = (count != '0) && ((state == IDLE) || hs_last);
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (!push && pop) count_next = count - CNT_W'(1);
    beat_next  = beat + BEAT_W'(1);
    shift_next = LSB_FIRST ? (shifter >> OUT_W) : (shifter << OUT_W);
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      in_ready_q   <= 1'b1;
      shifter      <= '0;
      beat         <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      block_done_q <= 1'b0;
    end else begin
      block_done_q <= 1'b0;
      if (push) begin
        mem[wr_ptr] <= bus.in_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      count      <= count_next;
      in_ready_q <= (count_next != FULL);

      case (state)
        IDLE: begin
          if (pop) begin
            shifter     <= mem[rd_ptr];
            beat        <= '0;
            state       <= SHIFT;
            out_valid_q <= 1'b1;
            out_last_q  <= ONE_BEAT;
          end
        end
        SHIFT: begin
          if (bus.out_ready) begin
            if (hs_last) begin
              block_done_q <= 1'b1;
              if (pop) begin
                shifter    <= mem[rd_ptr];
                beat       <= '0;
                out_last_q <= ONE_BEAT;
              end else begin
                // Clearing the shifter keeps out_data at zero while idle.
                shifter     <= '0;
                beat        <= '0;
                state       <= IDLE;
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
              end
            end else begin
              shifter    <= shift_next;
              beat       <= beat_next;
              out_last_q <= (beat_next == LAST_BEAT);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.fifo_count = count;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_last   = out_last_q;
  assign bus.block_done = block_done_q;
  assign bus.out_data   = LSB_FIRST ? shifter[OUT_W-1:0] : shifter[BLOCK_W-1 -: OUT_W];
endmodule

// File: tb/tb_output_serializer.sv
// Directed bench for output_serializer: MSB/LSB order, stall, full FIFO, reset, 32-bit beats.
module tb_output_serializer;
  logic clk = 1'b0;
  logic rst_;
  always #5 clk = ~clk;

  output_serializer_if #(.BLOCK_W(128), .OUT_W(8),  .DEPTH(2)) if_m ();
  output_serializer_if #(.BLOCK_W(128), .OUT_W(8),  .DEPTH(2)) if_l ();
  output_serializer_if #(.BLOCK_W(128), .OUT_W(32), .DEPTH(2)) if_w ();

  output_serializer #(.BLOCK_W(128), .OUT_W(8),  .DEPTH(2), .LSB_FIRST(1'b0))
    u_msb (.clk(clk), .rst_(rst_), .bus(if_m.slave));
  output_serializer #(.BLOCK_W(128), .OUT_W(8),  .DEPTH(2), .LSB_FIRST(1'b1))
    u_lsb (.clk(clk), .rst_(rst_), .bus(if_l.slave));
  output_serializer #(.BLOCK_W(128), .OUT_W(32), .DEPTH(2), .LSB_FIRST(1'b0))
    u_w32 (.clk(clk), .rst_(rst_), .bus(if_w.slave));

  typedef struct packed {
    logic        rdy;
    logic        vld;
    logic [31:0] dat;
    logic        last;
    logic        done;
  } vec_t;

  vec_t tv[$];
  int tests    = 0;
  int failures = 0;

  logic [127:0] blk_seq = 128'h000102030405060708090A0B0C0D0E0F;
  logic [127:0] blk_b   = 128'h101112131415161718191A1B1C1D1E1F;
  logic [127:0] blk_c   = 128'h202122232425262728292A2B2C2D2E2F;
  logic [127:0] blk_d   = 128'hDEADBEEFDEADBEEFDEADBEEFDEADBEEF;
  logic [127:0] blk_w32 = 128'h00112233445566778899AABBCCDDEEFF;
  logic [31:0]  w32_beats [4];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive_in(input int sel, input logic v, input logic [127:0] d);
    case (sel)
      0: begin if_m.in_valid = v; if_m.in_data = d; end
      1: begin if_l.in_valid = v; if_l.in_data = d; end
      default: begin if_w.in_valid = v; if_w.in_data = d; end
    endcase
  endtask

  task automatic drive_rdy(input int sel, input logic r);
    case (sel)
      0: if_m.out_ready = r;
      1: if_l.out_ready = r;
      default: if_w.out_ready = r;
    endcase
  endtask

  // Packed as {valid, data, last, done}.
  task automatic sample(input int sel, output logic [34:0] s);
    case (sel)
      0: s = {if_m.out_valid, 32'(if_m.out_data), if_m.out_last, if_m.block_done};
      1: s = {if_l.out_valid, 32'(if_l.out_data), if_l.out_last, if_l.block_done};
      default: s = {if_w.out_valid, if_w.out_data, if_w.out_last, if_w.block_done};
    endcase
  endtask

  task automatic sample_side(input int sel, output logic rdy, output logic [1:0] cnt);
    case (sel)
      0: begin rdy = if_m.in_ready; cnt = if_m.fifo_count; end
      1: begin rdy = if_l.in_ready; cnt = if_l.fifo_count; end
      default: begin rdy = if_w.in_ready; cnt = if_w.fifo_count; end
    endcase
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [31:0] d,
                              input logic l, input logic bd);
    vec_t x;
    x.rdy = r; x.vld = v; x.dat = d; x.last = l; x.done = bd;
    return x;
  endfunction

  // kind: 0 MSB-first, 1 MSB-first with 3-cycle stall at beat 5, 2 LSB-first, 3 32-bit beats.
  task automatic build(input int kind);
    int nb;
    tv.delete();
    nb = (kind == 3) ? 4 : 16;
    tv.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
    for (int k = 0; k < nb; k++) begin
      logic [31:0] d;
      case (kind)
        2:       d = 32'(15 - k);
        3:       d = w32_beats[k];
        default: d = 32'(k);
      endcase
      if (kind == 1 && k == 5)
        repeat (3) tv.push_back(mk(1'b0, 1'b1, d, 1'b0, 1'b0));
      tv.push_back(mk(1'b1, 1'b1, d, (k == nb - 1), 1'b0));
    end
    tv.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b1));
    tv.push_back(mk(1'b1, 1'b0, 32'h0, 1'b0, 1'b0));
  endtask

  // Pushes blk at the next edge, then checks one table record per cycle.
  task automatic run_table(input int sel, input logic [127:0] blk, input string name);
    logic [34:0] s;
    drive_in(sel, 1'b1, blk);
    @(negedge clk);
    drive_in(sel, 1'b0, '0);
    for (int i = 0; i < tv.size(); i++) begin
      sample(sel, s);
      check($sformatf("%s[%0d]", name, i), 128'(s),
            128'({tv[i].vld, tv[i].dat, tv[i].last, tv[i].done}));
      drive_rdy(sel, tv[i].rdy);
      @(negedge clk);
    end
  endtask

  task automatic full_fifo();
    logic [34:0] s;
    logic v, l, bd, gap, ir;
    logic [31:0] d;
    logic [1:0] cnt;
    int collected, dones;
    drive_rdy(0, 1'b0);
    drive_in(0, 1'b1, blk_seq); @(negedge clk);
    drive_in(0, 1'b1, blk_b);   @(negedge clk);
    drive_in(0, 1'b1, blk_c);   @(negedge clk);
    drive_in(0, 1'b1, blk_d);
    sample_side(0, ir, cnt);
    check("ff_count_full", 128'(cnt), 128'd2);
    check("ff_in_ready_full", 128'(ir), 128'd0);
    sample(0, s);
    check("ff_a_loaded", 128'(s), 128'({1'b1, 32'h0, 1'b0, 1'b0}));
    @(negedge clk);
    sample_side(0, ir, cnt);
    check("ff_fourth_refused", 128'(cnt), 128'd2);
    drive_in(0, 1'b0, '0);
    drive_rdy(0, 1'b1);
    collected = 0; dones = 0; gap = 1'b0;
    for (int cyc = 0; cyc < 200 && collected < 48; cyc++) begin
      sample(0, s);
      {v, d, l, bd} = s;
      if (bd) dones++;
      if (v) begin
        check($sformatf("ff_data[%0d]", collected), 128'(d), 128'(collected));
        check($sformatf("ff_last[%0d]", collected), 128'(l), 128'(collected % 16 == 15));
        if (collected == 15 || collected == 16) begin
          sample_side(0, ir, cnt);
          check($sformatf("ff_in_ready[%0d]", collected), 128'(ir), 128'(collected == 16));
        end
        collected++;
      end else if (collected > 0) begin
        gap = 1'b1;
      end
      @(negedge clk);
    end
    check("ff_beats", 128'(collected), 128'd48);
    check("ff_gap", 128'(gap), 128'd0);
    sample(0, s);
    check("ff_idle_valid", 128'(s[34]), 128'd0);
    for (int k = 0; k < 3; k++) begin
      sample(0, s);
      if (s[0]) dones++;
      @(negedge clk);
    end
    check("ff_done_pulses", 128'(dones), 128'd3);
    sample_side(0, ir, cnt);
    check("ff_count_empty", 128'(cnt), 128'd0);
  endtask

  task automatic reset_mid();
    logic [34:0] s;
    logic found, bad, ir;
    logic [1:0] cnt;
    drive_rdy(0, 1'b1);
    drive_in(0, 1'b1, blk_seq); @(negedge clk);
    drive_in(0, 1'b1, blk_b);   @(negedge clk);
    drive_in(0, 1'b0, '0);
    found = 1'b0;
    for (int cyc = 0; cyc < 40 && !found; cyc++) begin
      sample(0, s);
      if (s[34] && s[33:2] == 32'h7) found = 1'b1;
      else @(negedge clk);
    end
    check("rst_reach_beat7", 128'(found), 128'd1);
    sample_side(0, ir, cnt);
    check("rst_b_buffered", 128'(cnt), 128'd1);
    rst_ = 1'b1;
    @(negedge clk);
    rst_ = 1'b0;
    sample(0, s);
    check("rst_outputs", 128'(s), 128'd0);
    sample_side(0, ir, cnt);
    check("rst_count", 128'(cnt), 128'd0);
    check("rst_in_ready", 128'(ir), 128'd1);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      sample(0, s);
      if (s[34] || s[0]) bad = 1'b1;
    end
    check("rst_discarded", 128'(bad), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [34:0] s;
    logic ir;
    logic [1:0] cnt;
    w32_beats[0] = 32'h00112233;
    w32_beats[1] = 32'h44556677;
    w32_beats[2] = 32'h8899AABB;
    w32_beats[3] = 32'hCCDDEEFF;
    rst_ = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_in(i, 1'b0, '0);
      drive_rdy(i, 1'b0);
    end
    repeat (3) @(negedge clk);
    rst_ = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample(i, s);
      check($sformatf("reset_out[%0d]", i), 128'(s), 128'd0);
      sample_side(i, ir, cnt);
      check($sformatf("reset_in_ready[%0d]", i), 128'(ir), 128'd1);
      check($sformatf("reset_count[%0d]", i), 128'(cnt), 128'd0);
    end

    build(0); run_table(0, blk_seq, "msb");
    build(1); run_table(0, blk_seq, "stall");
    build(2); run_table(1, blk_seq, "lsb");
    build(3); run_table(2, blk_w32, "w32");
    full_fifo();
    repeat (2) @(negedge clk);
    reset_mid();
    build(0); run_table(0, blk_seq, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end
endmodule

// File: doc/output_serializer.md
Name: output_serializer

Overview:
- Parametrised successor to the single-block ciphertext output latch. Accepts whole cipher blocks from the round transformer into a small block FIFO, then emits them as OUT_W-bit beats over a valid/ready stream.
- Adds backpressure, byte-order mode, buffering of back-to-back blocks, and a last-beat marker.
- Sits between the engine round transformer and the external data port.

Parameters:
- BLOCK_W, 128, cipher block width in bits; must be a multiple of OUT_W.
- OUT_W, 8, output beat width in bits.
- DEPTH, 2, block FIFO depth in blocks; power of two, at least 1.
- LSB_FIRST, 0, 0 emits the most significant beat first; 1 emits the least significant beat first.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_  in  1  synchronous, active-high reset.
- in_valid  in  1  block offered by the transformer.
- in_ready  out  1  FIFO can accept a block.
- in_data  in  BLOCK_W  ciphertext block.
- out_data  out  OUT_W  current beat.
- out_valid  out  1  out_data is valid (data_ok).
- out_ready  in  1  downstream accepts the beat.
- out_last  out  1  current beat is the final beat of its block.
- block_done  out  1  one-cycle pulse: block fully emitted (output_read).
- fifo_count  out  $clog2(DEPTH+1)  blocks buffered, excluding the block in the shifter.

Behaviour:
- BEATS = BLOCK_W/OUT_W. The beat counter is $clog2(BEATS) bits wide.
- Reset (rst_=1 at a rising edge): FIFO empty, fifo_count=0, state IDLE, shifter=0, out_data=0, out_valid=0, out_last=0, block_done=0. in_ready reads 1 in the cycle after reset.
- Reset mid-operation discards all buffered and in-flight data. No block_done is issued for a discarded block.
- Input side:
  - A push occurs when in_valid && in_ready at an edge.
  - in_ready = (fifo_count != DEPTH); there is no bypass when full.
  - A push and a pop on the same edge leave fifo_count unchanged.
  - A pop while the FIFO is full frees a slot; in_ready rises the next cycle.
- States: IDLE and SHIFT.
  - IDLE: if fifo_count > 0 at an edge, pop the head into the shifter, set beat counter to 0, and go to SHIFT.
  - SHIFT: out_valid=1. out_data is the top OUT_W bits of the shifter (LSB_FIRST=0) or the bottom OUT_W bits (LSB_FIRST=1).
  - On out_valid && out_ready, shift the shifter by OUT_W (left for LSB_FIRST=0, right for LSB_FIRST=1, zero-filled) and increment the beat counter.
  - out_last=1 while beat counter == BEATS-1.
- Final beat handshake:
  - block_done pulses for exactly one cycle after that edge.
  - If the FIFO is non-empty, the next block loads on that same edge and SHIFT continues with no bubble.
  - If the FIFO is empty, go to IDLE with out_valid=0 and out_data=0.
- Stall: while out_valid && !out_ready, out_data, out_last, the shifter and the beat counter are held stable.
- Latency: a push at edge E0 into an idle, empty block gives the first beat valid after E1. A sustained stream delivers 1 beat per cycle.
- out_data is 0 whenever out_valid=0.
- BEATS=1 (OUT_W=BLOCK_W): out_last=1 on every beat, and block_done follows each handshake.

Test Plan:
- MSB-first order: default parameters, push 0x000102030405060708090A0B0C0D0E0F, out_ready=1 -> out_data 0x00,0x01,...,0x0F on 16 consecutive cycles starting one cycle after the push edge. out_last is high only on 0x0F; block_done pulses once after the 0x0F handshake.
- LSB-first mode: LSB_FIRST=1, same block -> beats 0x0F,0x0E,...,0x00; out_last on 0x00.
- Backpressure: drop out_ready for 3 cycles at beat 0x05 -> out_data held at 0x05 with out_valid=1, then resumes at 0x06. Total is still 16 beats, with no duplicates or drops.
- Back-to-back and full FIFO: DEPTH=2, push blocks A, B and C on consecutive cycles with out_ready=0 -> A loads into the shifter, B and C fill the FIFO, fifo_count=2 and in_ready=0. A fourth push is refused. Release out_ready -> 48 contiguous beats (A, B, C), three block_done pulses, and in_ready rises the cycle after B's load pop.
- Reset mid-block: assert rst_ for 1 cycle at beat 7 of A while B is buffered -> next cycle out_valid=0, fifo_count=0, no block_done. A fresh push then emits correctly from beat 0.
- Width variant: OUT_W=32, push 0x00112233_44556677_8899AABB_CCDDEEFF -> 4 beats 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF, with out_last on the fourth.
